// File: rtl/fir_pkg.sv
// Shared FIR-datapath definitions: pulse_stretch state encoding.
// Unused code 2'd3 is never produced and recovers to idle.
package fir_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_HOLD   = ST_HOLD
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping; cleared only by reset.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (inc)
      q <= sat_inc(q);
  end

endmodule

// File: rtl/pulse_stretch.sv
// Strobe-to-level stretcher with post-pulse holdoff and dropped-trigger accounting.
// Define PULSE_STRETCH_RETRIGGER_EN to let a trig during the level reload its length.
module pulse_stretch
  import fir_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [CNT_W-1:0]  len,
  output logic              level,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [HCNT_W-1:0] hcnt, hcnt_nxt;
  logic              level_nxt;
  logic              done_nxt;
  logic              refuse;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    level_nxt = level;
    done_nxt  = 1'b0;
    refuse    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig && (len != '0)) begin
          cnt_nxt   = len;
          level_nxt = 1'b1;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // With retrigger enabled nothing in ACTIVE is a drop; len==0 is simply ignored.
        refuse = trig && !RETRIG_EN;
        if (RETRIG_EN && trig && (len != '0)) begin
          cnt_nxt = len;
        end else if (cnt <= CNT_W'(1)) begin
          level_nxt = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          hcnt_nxt  = HCNT_W'(HOLDOFF);
          state_nxt = (HOLDOFF > 0) ? S_HOLD : S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        refuse = trig;
        if (hcnt <= HCNT_W'(1)) begin
          hcnt_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          hcnt_nxt = hcnt - HCNT_W'(1);
        end
      end
      default: begin
        level_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      level <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hcnt  <= hcnt_nxt;
      level <= level_nxt;
      done  <= done_nxt;
      drop  <= refuse;
    end
  end

  assign busy = (state != S_IDLE);

  sat_cnt #(.W(DROP_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (refuse),
    .q     (drop_cnt)
  );

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: stimulus queues expected level lengths,
// a negedge monitor measures each level pulse and checks the accompanying done.
module tb_pulse_stretch;

  localparam int CNT_W   = 8;
  localparam int HOLDOFF = 2;
  localparam int DROP_W  = 2;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              trig  = 1'b0;
  logic [CNT_W-1:0]  len   = '0;
  logic              level, busy, done, drop;
  logic [DROP_W-1:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_len[$];
  int drop_seen = 0;
  int done_seen = 0;

  logic rst_prev   = 1'b1;
  logic prev_level = 1'b0;
  int   run        = 0;

  always #5 clk = ~clk;

  pulse_stretch #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .len      (len),
    .level    (level),
    .busy     (busy),
    .done     (done),
    .drop     (drop),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input int l);
    trig = 1'b1;
    len  = CNT_W'(l);
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("idle_timeout", busy, 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Monitor: measure every level pulse, pop its expected length at the falling edge.
  always @(negedge clk) begin
    if (rst_prev) begin
      run        = 0;
      prev_level = 1'b0;
    end else begin
      if (level) run++;
      if (prev_level && !level) begin
        if (exp_len.size() == 0) check("pulse_unexpected_len", run, 0);
        else check("pulse_len", run, exp_len.pop_front());
        check("done_at_fall", done, 1);
        run = 0;
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      prev_level = level;
      if (drop) drop_seen++;
      if (done) done_seen++;
    end
    rst_prev = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ds, dn, mid;
    logic [3:0]  acc;
    logic [17:0] vec;

    repeat (3) tick();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    tick();

    // 1: len=5 -> 5 high cycles, busy 5+HOLDOFF = 7 cycles
    ds = drop_seen; dn = done_seen;
    exp_len.push_back(5);
    fire(5);
    check("t1_level_on", level, 1);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check("t1_busy_cycles", n, 7);
    tick();
    check("t1_done_count", done_seen - dn, 1);
    check("t1_drop_cnt", drop_cnt, 0);

    // 2: len=0 is ignored entirely
    ds = drop_seen; dn = done_seen;
    fire(0);
    acc = '0;
    repeat (4) begin
      acc |= {level, busy, done, drop};
      tick();
    end
    check("t2_quiet", acc, 0);
    check("t2_drops", drop_seen - ds, 0);

    // 3: second trig three cycles into a len=10 pulse
    do_reset();
    ds = drop_seen; dn = done_seen;
    exp_len.push_back(RETRIG ? 13 : 10);
    fire(10);
    tick();
    tick();
    fire(10);
    wait_idle();
    check("t3_drop_pulses", drop_seen - ds, RETRIG ? 0 : 1);
    check("t3_drop_cnt", drop_cnt, RETRIG ? 0 : 1);
    check("t3_done_count", done_seen - dn, 1);

    // 4: trig in first HOLD cycle refused, trig two cycles later accepted
    do_reset();
    ds = drop_seen; dn = done_seen;
    exp_len.push_back(4);
    exp_len.push_back(4);
    fire(4);
    n = 0;
    while (level && n < 50) begin
      n++;
      tick();
    end
    check("t4_first_len", n, 4);
    fire(4);
    tick();
    fire(4);
    check("t4_accept", level, 1);
    wait_idle();
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_drop_pulses", drop_seen - ds, 1);
    check("t4_done_count", done_seen - dn, 2);

    // 5: trig held 18 cycles with len=3; drop_cnt saturates at 3
    do_reset();
    if (RETRIG) exp_len.push_back(20);
    else repeat (3) exp_len.push_back(3);
    trig = 1'b1;
    len  = CNT_W'(3);
    vec  = '0;
    mid  = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      vec = {vec[16:0], level};
      if (i == 5) mid = drop_cnt;
    end
    trig = 1'b0;
    check("t5_level_pattern", vec, RETRIG ? 18'h3FFFF : 18'b111000_111000_111000);
    check("t5_drop_cnt_mid", mid, RETRIG ? 0 : 3);
    wait_idle();
    check("t5_drop_cnt_final", drop_cnt, RETRIG ? 0 : 3);

    // 6: reset in cycle 2 of a len=8 pulse, then a normal pulse
    do_reset();
    fire(8);
    fire(8);
    check("t6_pre_drop_cnt", drop_cnt, RETRIG ? 0 : 1);
    reset = 1'b1;
    tick();
    check("t6_level", level, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    dn = done_seen;
    exp_len.push_back(2);
    fire(2);
    check("t6_level_on", level, 1);
    wait_idle();
    check("t6_done_count", done_seen - dn, 1);

    check("pending_pulses", exp_len.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
